// File: rtl/display_pkg.sv
// Shared types and constants for the laser-projector display output stage.
package display_pkg;

   localparam int SPI_WORD_W = 16;
   localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
   } point_t;

   typedef enum logic {
      WAIT,
      SEND
   } state_t;

endpackage

// File: rtl/spi_dac_tx.sv
// Mode-0 SPI transmitter for one 16-bit MCP4921-style DAC word, MSB first.
module spi_dac_tx
   import display_pkg::*;
#(
   parameter int SCLK_DIV = 2
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [SPI_WORD_W-1:0] data,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  cs,
   output logic                  busy,
   output logic                  done
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   logic [DIV_W-1:0]      div_cnt;
   logic [4:0]            tog_cnt;
   logic [SPI_WORD_W-1:0] shreg;
   logic                  active;
   logic                  tick;

   assign tick = active && (div_cnt == DIV_W'(SCLK_DIV - 1));
   assign done = tick && (tog_cnt == 5'd31);
   assign busy = active;

   // 32 sclk toggles per word; the 32nd toggle is the final falling edge and releases cs.
   always_ff @(posedge clock) begin
      if (reset) begin
         active  <= 1'b0;
         cs      <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         div_cnt <= '0;
         tog_cnt <= '0;
         shreg   <= '0;
      end else if (start && !active) begin
         active  <= 1'b1;
         cs      <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= data[SPI_WORD_W-1];
         shreg   <= data;
         div_cnt <= '0;
         tog_cnt <= '0;
      end else if (active) begin
         if (tick) begin
            div_cnt <= '0;
            tog_cnt <= tog_cnt + 5'd1;
            if (tog_cnt == 5'd31) begin
               active <= 1'b0;
               cs     <= 1'b1;
               sclk   <= 1'b0;
               mosi   <= 1'b0;
            end else begin
               sclk <= ~sclk;
               if (sclk) begin
                  shreg <= {shreg[SPI_WORD_W-2:0], 1'b0};
                  mosi  <= shreg[SPI_WORD_W-2];
               end
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/display_controller.sv
// Steps through a self-generated square test pattern, driving X/Y SPI DACs and RGB laser PWM.
module display_controller
   import display_pkg::*;
#(
   parameter int         SCLK_DIV    = 2,
   parameter int         SIDE_POINTS = 16,
   parameter int         SQ_LO       = 1024,
   parameter int         SQ_STEP     = 128,
   parameter logic [3:0] DAC_CFG     = DAC_CFG_DEFAULT
)(
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic [31:0] frame_delay,
   output logic        x_sclk,
   output logic        y_sclk,
   output logic        x_mosi,
   output logic        y_mosi,
   output logic        x_cs,
   output logic        y_cs,
   output logic        r_pwm,
   output logic        g_pwm,
   output logic        b_pwm
);

   localparam int NPTS  = 4 * SIDE_POINTS;
   localparam int IDX_W = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam int SQ_HI = SQ_LO + SIDE_POINTS * SQ_STEP;

   function automatic point_t pattern_point(input logic [IDX_W-1:0] p);
      int     side;
      int     k;
      int     x;
      int     y;
      point_t pt;
      side = int'(p) / SIDE_POINTS;
      k    = int'(p) % SIDE_POINTS;
      x    = 0;
      y    = 0;
      pt   = '0;
      case (side)
         0: begin
            x = SQ_LO + k * SQ_STEP;
            y = SQ_LO;
            pt.r = 8'hFF;
         end
         1: begin
            x = SQ_HI;
            y = SQ_LO + k * SQ_STEP;
            pt.g = 8'hFF;
         end
         2: begin
            x = SQ_HI - k * SQ_STEP;
            y = SQ_HI;
            pt.b = 8'hFF;
         end
         default: begin
            x = SQ_LO;
            y = SQ_HI - k * SQ_STEP;
            pt.r = 8'hFF;
            pt.g = 8'hFF;
            pt.b = 8'hFF;
         end
      endcase
      pt.x = x[11:0];
      pt.y = y[11:0];
      return pt;
   endfunction

   state_t                state;
   logic [31:0]           delay_cnt;
   logic [IDX_W-1:0]      point_idx;
   logic [7:0]            r_duty;
   logic [7:0]            g_duty;
   logic [7:0]            b_duty;
   logic [7:0]            pwm_cnt;
   point_t                cur_point;
   logic [SPI_WORD_W-1:0] x_word;
   logic [SPI_WORD_W-1:0] y_word;
   logic                  wait_done;
   logic                  start;
   logic                  x_busy;
   logic                  y_busy;
   logic                  x_done;
   logic                  y_done;
   logic                  spi_busy;
   logic                  spi_done;

   assign cur_point = pattern_point(point_idx);
   assign x_word    = {DAC_CFG, cur_point.x};
   assign y_word    = {DAC_CFG, cur_point.y};
   assign spi_busy  = x_busy | y_busy;
   assign spi_done  = x_done & y_done;

   // Widened compare so frame_delay of 0 or 1 both mean "start as soon as the DACs are idle".
   assign wait_done = ({1'b0, delay_cnt} + 33'd1) >= {1'b0, frame_delay};
   assign start     = (state == WAIT) && wait_done && !spi_busy;

   spi_dac_tx #(.SCLK_DIV(SCLK_DIV)) u_x_dac (
      .clock (clock_in),
      .reset (reset_in),
      .start (start),
      .data  (x_word),
      .sclk  (x_sclk),
      .mosi  (x_mosi),
      .cs    (x_cs),
      .busy  (x_busy),
      .done  (x_done)
   );

   spi_dac_tx #(.SCLK_DIV(SCLK_DIV)) u_y_dac (
      .clock (clock_in),
      .reset (reset_in),
      .start (start),
      .data  (y_word),
      .sclk  (y_sclk),
      .mosi  (y_mosi),
      .cs    (y_cs),
      .busy  (y_busy),
      .done  (y_done)
   );

   // Colour is latched as cs rises, so the lasers follow the beam once it has been positioned.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state     <= WAIT;
         delay_cnt <= '0;
         point_idx <= '0;
         r_duty    <= '0;
         g_duty    <= '0;
         b_duty    <= '0;
      end else begin
         delay_cnt <= start ? 32'd0 : delay_cnt + 32'd1;
         case (state)
            WAIT: begin
               if (start) begin
                  state <= SEND;
               end
            end
            SEND: begin
               if (spi_done) begin
                  r_duty <= cur_point.r;
                  g_duty <= cur_point.g;
                  b_duty <= cur_point.b;
                  if (point_idx == IDX_W'(NPTS - 1)) begin
                     point_idx <= '0;
                  end else begin
                     point_idx <= point_idx + IDX_W'(1);
                  end
                  state <= WAIT;
               end
            end
            default: state <= WAIT;
         endcase
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         pwm_cnt <= '0;
         r_pwm   <= 1'b0;
         g_pwm   <= 1'b0;
         b_pwm   <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         r_pwm   <= (pwm_cnt < r_duty);
         g_pwm   <= (pwm_cnt < g_duty);
         b_pwm   <= (pwm_cnt < b_duty);
      end
   end

endmodule

// File: tb/tb_display_controller.sv
// Scoreboard bench for display_controller: SPI decode monitor checked against a square-walk model.
module tb_display_controller;

   localparam int SIDE_POINTS = 16;
   localparam int SQ_LO       = 1024;
   localparam int SQ_STEP     = 128;
   localparam int SQ_HI       = SQ_LO + SIDE_POINTS * SQ_STEP;
   localparam int NPTS        = 4 * SIDE_POINTS;

   typedef struct packed {
      logic [15:0] xw;
      logic [15:0] yw;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
   } exp_t;

   logic        clock_in = 1'b0;
   logic        reset_in = 1'b1;
   logic [31:0] frame_delay = 32'd0;
   logic        x_sclk, y_sclk, x_mosi, y_mosi, x_cs, y_cs;
   logic        r_pwm, g_pwm, b_pwm;

   exp_t ref_pts[NPTS];
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int edge_idx = -1;
   int exp_period = 0;
   int exp_first_fall = -1;

   display_controller dut (
      .clock_in    (clock_in),
      .reset_in    (reset_in),
      .frame_delay (frame_delay),
      .x_sclk      (x_sclk),
      .y_sclk      (y_sclk),
      .x_mosi      (x_mosi),
      .y_mosi      (y_mosi),
      .x_cs        (x_cs),
      .y_cs        (y_cs),
      .r_pwm       (r_pwm),
      .g_pwm       (g_pwm),
      .b_pwm       (b_pwm)
   );

   always #5 clock_in = ~clock_in;

   // Edge 0 is the first rising edge at which reset is no longer asserted.
   always @(posedge clock_in) begin
      if (reset_in) edge_idx = -1;
      else edge_idx = edge_idx + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // The beam walks the square corner to corner; each side has its own colour.
   task automatic buildModel;
      int          cx[4];
      int          cy[4];
      int          dx[4];
      int          dy[4];
      logic [23:0] col[4];
      logic [31:0] x;
      logic [31:0] y;
      cx  = '{SQ_LO, SQ_HI, SQ_HI, SQ_LO};
      cy  = '{SQ_LO, SQ_LO, SQ_HI, SQ_HI};
      dx  = '{1, 0, -1, 0};
      dy  = '{0, 1, 0, -1};
      col = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < SIDE_POINTS; k++) begin
            x = cx[s] + dx[s] * k * SQ_STEP;
            y = cy[s] + dy[s] * k * SQ_STEP;
            ref_pts[s * SIDE_POINTS + k].xw = {4'b0011, x[11:0]};
            ref_pts[s * SIDE_POINTS + k].yw = {4'b0011, y[11:0]};
            ref_pts[s * SIDE_POINTS + k].r  = col[s][23:16];
            ref_pts[s * SIDE_POINTS + k].g  = col[s][15:8];
            ref_pts[s * SIDE_POINTS + k].b  = col[s][7:0];
         end
      end
   endtask

   // Reset the DUT, pick the frame delay, queue the expected words from point 0, then release.
   task automatic applyStimulus(input int fd, input int nwords);
      @(negedge clock_in);
      reset_in = 1'b1;
      repeat (2) @(negedge clock_in);
      exp_q.delete();
      frame_delay    = fd;
      exp_period     = (fd > 65) ? fd : 65;
      exp_first_fall = (fd <= 1) ? 0 : fd - 1;
      for (int i = 0; i < nwords; i++) exp_q.push_back(ref_pts[i % NPTS]);
      reset_in = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock_in);
         n++;
      end
      checkOutput("drain_pending_words", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic waitCsFall(input int budget);
      int n = 0;
      while (x_cs !== 1'b0 && n < budget) begin
         @(negedge clock_in);
         n++;
      end
      checkOutput("cs_fall_seen", {31'd0, x_cs}, 0);
   endtask

   // Monitor state
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        in_word = 1'b0;
   logic        lane_bad, stab_bad, pend, pend_x, pend_y;
   logic [15:0] xsh, ysh;
   int          low_len, nbits, prev_fall;
   logic        have_colour = 1'b0;
   logic [7:0]  cur_r, cur_g, cur_b;
   int          win_len, win_r, win_g, win_b;
   exp_t        e;

   function automatic logic colourOk(input logic [7:0] duty, input int len, input int hi);
      if (duty == 8'd0) return (hi == 0);
      return ((len - hi) <= (len / 256 + 1));
   endfunction

   // Decode both SPI lanes on every falling clock edge and score completed words.
   always @(negedge clock_in) begin
      if (reset_in) begin
         in_word     = 1'b0;
         have_colour = 1'b0;
         prev_fall   = -1;
         prev_cs     = 1'b1;
         prev_sclk   = 1'b0;
         pend        = 1'b0;
      end else begin
         if (have_colour) begin
            win_len++;
            win_r += int'(r_pwm);
            win_g += int'(g_pwm);
            win_b += int'(b_pwm);
         end
         if (prev_cs && !x_cs) begin
            in_word  = 1'b1;
            low_len  = 0;
            nbits    = 0;
            lane_bad = (x_cs !== y_cs);
            stab_bad = 1'b0;
            pend     = 1'b0;
            if (prev_fall < 0) begin
               if (exp_first_fall >= 0) checkOutput("first_cs_fall_cycle", edge_idx, exp_first_fall);
            end else begin
               checkOutput("cs_fall_period", edge_idx - prev_fall, exp_period);
            end
            prev_fall = edge_idx;
         end
         if (in_word && !x_cs) begin
            low_len++;
            if (x_cs !== y_cs || x_sclk !== y_sclk) lane_bad = 1'b1;
            if (pend) begin
               if (x_mosi !== pend_x || y_mosi !== pend_y) stab_bad = 1'b1;
               pend = 1'b0;
            end
            if (!prev_sclk && x_sclk) begin
               xsh    = {xsh[14:0], x_mosi};
               ysh    = {ysh[14:0], y_mosi};
               nbits++;
               pend   = 1'b1;
               pend_x = x_mosi;
               pend_y = y_mosi;
            end
         end
         if (in_word && !prev_cs && x_cs) begin
            in_word = 1'b0;
            checkOutput("cs_low_cycles", low_len, 64);
            checkOutput("sclk_rising_edges", nbits, 16);
            checkOutput("lane_timing_match", {31'd0, lane_bad | (x_cs !== y_cs)}, 0);
            checkOutput("mosi_stable_at_rise", {31'd0, stab_bad}, 0);
            checkOutput("idle_after_word", {29'd0, x_sclk, x_mosi, y_mosi}, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got x=0x%0h y=0x%0h, required no word", xsh, ysh);
            end else begin
               e = exp_q.pop_front();
               checkOutput("x_word", {16'd0, xsh}, {16'd0, e.xw});
               checkOutput("y_word", {16'd0, ysh}, {16'd0, e.yw});
               if (have_colour) begin
                  checkOutput("colour_window",
                     {29'd0, colourOk(cur_r, win_len, win_r), colourOk(cur_g, win_len, win_g),
                      colourOk(cur_b, win_len, win_b)}, 32'd7);
               end
               cur_r = e.r;
               cur_g = e.g;
               cur_b = e.b;
               have_colour = 1'b1;
               win_len = 0;
               win_r = 0;
               win_g = 0;
               win_b = 0;
            end
         end
         prev_cs   = x_cs;
         prev_sclk = x_sclk;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int f;
      int n;
      int hr, hg, hb;
      buildModel();

      // Outputs idle while reset is held.
      repeat (2) begin
         @(negedge clock_in);
         checkOutput("reset_outputs", {23'd0, x_cs, y_cs, x_sclk, y_sclk, x_mosi, y_mosi, r_pwm, g_pwm, b_pwm},
                     {23'd0, 9'b110000000});
      end

      // Long frame delay: first point, then exact red duty over a full PWM period.
      f = $urandom_range(4000, 2000);
      applyStimulus(f, 1);
      waitDrain(f + 300);
      repeat (2) @(negedge clock_in);
      hr = 0;
      hg = 0;
      hb = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clock_in);
         hr += int'(r_pwm);
         hg += int'(g_pwm);
         hb += int'(b_pwm);
      end
      checkOutput("red_high_cycles", hr, 255);
      checkOutput("green_high_cycles", hg, 0);
      checkOutput("blue_high_cycles", hb, 0);

      // Full square plus wrap to point 0.
      applyStimulus(100, NPTS + 1);
      waitDrain((NPTS + 1) * 100 + 300);

      // Back-to-back words.
      applyStimulus(0, NPTS + 6);
      waitDrain((NPTS + 6) * 65 + 300);

      // Random frame delays.
      for (int t = 0; t < 2; t++) begin
         f = $urandom_range(200, 66);
         applyStimulus(f, 10);
         waitDrain(10 * f + 300);
      end

      // Reset during a transfer, then confirm the pattern restarts at point 0.
      for (int t = 0; t < 2; t++) begin
         f = $urandom_range(300, 70);
         n = $urandom_range(6, 2);
         applyStimulus(f, n);
         waitDrain(n * f + 300);
         waitCsFall(f + 100);
         repeat (29) @(negedge clock_in);
         reset_in = 1'b1;
         @(negedge clock_in);
         checkOutput("reset_mid_transfer", {28'd0, x_cs, y_cs, x_sclk, y_sclk}, {28'd0, 4'b1100});
         applyStimulus(f, 4);
         waitDrain(4 * f + 300);
      end

      @(negedge clock_in);
      reset_in = 1'b1;
      repeat (2) @(negedge clock_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
